ctrl_fsm: RTL and testbench

Multicycle control unit for the RV32I core: decodes the instruction register, sequences FETCH/DECODE/EXEC/MEM over a ready-handshaked memory port, and drives every datapath enable and mux select. It is the producer of the 4-bit ALU operation code. It therefore owns the opcode encoding the ALU consumes: add 0, sll 1, slt 2, sltu 3, xor 4, srl 5, or 6, and 7, sub 8, copy-A 9, sra 13. The block sits between the IR/branch comparator and the register file, PC, memory and ALU muxes.

---
 rtl/ctrl_fsm_if.sv | 33 +++
 rtl/ctrl_fsm.sv | 204 ++++++++++++++++++++
 tb/tb_ctrl_fsm.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/ctrl_fsm_if.sv
// Control-unit bundle: IR/comparator inputs and every datapath enable/select
// driven by ctrl_fsm. master = the control unit, slave = datapath side.
interface ctrl_fsm_if;
    logic [31:0] instr;
    logic        mem_ready;
    logic        br_taken;
    logic        mem_req;
    logic        mem_we;
    logic        mem_addr_sel;
    logic        ir_we;
    logic        pc_we;
    logic [1:0]  pc_sel;
    logic        rf_we;
    logic [1:0]  wb_sel;
    logic [3:0]  alu_op;
    logic [1:0]  alu_a_sel;
    logic        alu_b_sel;
    logic        retire;
    logic        illegal;
    logic [2:0]  state;

    modport master (
        input  instr, mem_ready, br_taken,
        output mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel, rf_we,
               wb_sel, alu_op, alu_a_sel, alu_b_sel, retire, illegal, state
    );

    modport slave (
        output instr, mem_ready, br_taken,
        input  mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel, rf_we,
               wb_sel, alu_op, alu_a_sel, alu_b_sel, retire, illegal, state
    );
endinterface

// File: rtl/ctrl_fsm.sv
// Multicycle RV32I control unit: FETCH/DECODE/EXEC/MEM sequencing, legality
// check with sticky HALT, and all datapath enables / mux selects.
module ctrl_fsm (
    input  logic       clk,
    input  logic       rst_n,
    ctrl_fsm_if.master bus
);
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        HALT   = 3'd4
    } state_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_ALT     = 7'b0100000;

    localparam logic [3:0] ALU_ADD    = 4'd0;
    localparam logic [3:0] ALU_COPYA  = 4'd9;

    localparam logic [1:0] PC_PLUS4   = 2'd0;
    localparam logic [1:0] PC_ALU     = 2'd1;
    localparam logic [1:0] PC_ALU_AL  = 2'd2;
    localparam logic [1:0] WB_ALU     = 2'd0;
    localparam logic [1:0] WB_MEM     = 2'd1;
    localparam logic [1:0] WB_PC4     = 2'd2;
    localparam logic [1:0] A_RS1      = 2'd0;
    localparam logic [1:0] A_PC       = 2'd1;
    localparam logic [1:0] A_UIMM     = 2'd2;
    localparam logic       B_RS2      = 1'b0;
    localparam logic       B_IMM      = 1'b1;

    state_t      state_q, state_d;
    logic        illegal_q;
    logic        legal;
    logic [6:0]  opcode;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic        is_ldst;
    logic        unused_bits;

    assign opcode      = bus.instr[6:0];
    assign funct3      = bus.instr[14:12];
    assign funct7      = bus.instr[31:25];
    assign is_ldst     = (opcode == OPC_LOAD) || (opcode == OPC_STORE);
    assign unused_bits = ^{bus.instr[24:15], bus.instr[11:7]};

    always_comb begin
        legal = 1'b0;
        case (opcode)
            OPC_OP:     legal = (funct7 == 7'd0) ||
                                (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101));
            OPC_OPIMM: begin
                case (funct3)
                    3'b001:  legal = (funct7 == 7'd0);
                    3'b101:  legal = (funct7 == 7'd0) || (funct7 == F7_ALT);
                    default: legal = 1'b1;
                endcase
            end
            OPC_LOAD:   legal = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
            OPC_STORE:  legal = (funct3 <= 3'b010);
            OPC_BRANCH: legal = (funct3[2:1] != 2'b01);
            OPC_JALR:   legal = (funct3 == 3'b000);
            OPC_JAL, OPC_LUI, OPC_AUIPC: legal = 1'b1;
            default:    legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == DECODE && !legal)
                illegal_q <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:   if (bus.mem_ready) state_d = DECODE;
            DECODE:  state_d = legal ? EXEC : HALT;
            EXEC:    state_d = is_ldst ? MEM : FETCH;
            MEM:     if (bus.mem_ready) state_d = FETCH;
            HALT:    state_d = HALT;
            default: state_d = FETCH;
        endcase
    end

    // Everything is forced low while rst_n is held, even though the
    // register already sits in FETCH, so the datapath sees a quiet bus.
    always_comb begin
        bus.mem_req      = 1'b0;
        bus.mem_we       = 1'b0;
        bus.mem_addr_sel = 1'b0;
        bus.ir_we        = 1'b0;
        bus.pc_we        = 1'b0;
        bus.pc_sel       = PC_PLUS4;
        bus.rf_we        = 1'b0;
        bus.wb_sel       = WB_ALU;
        bus.alu_op       = ALU_ADD;
        bus.alu_a_sel    = A_RS1;
        bus.alu_b_sel    = B_RS2;
        bus.retire       = 1'b0;
        bus.illegal      = rst_n & illegal_q;
        bus.state        = rst_n ? state_q : FETCH;
        if (rst_n) begin
            case (state_q)
                FETCH: begin
                    bus.mem_req = 1'b1;
                    bus.ir_we   = bus.mem_ready;
                end
                EXEC: begin
                    case (opcode)
                        OPC_OP: begin
                            bus.alu_op = {bus.instr[30], funct3};
                            bus.rf_we  = 1'b1;
                            bus.pc_we  = 1'b1;
                            bus.retire = 1'b1;
                        end
                        OPC_OPIMM: begin
                            bus.alu_op    = (funct3 == 3'b101) ? {bus.instr[30], funct3}
                                                               : {1'b0, funct3};
                            bus.alu_b_sel = B_IMM;
                            bus.rf_we     = 1'b1;
                            bus.pc_we     = 1'b1;
                            bus.retire    = 1'b1;
                        end
                        OPC_LUI: begin
                            bus.alu_op    = ALU_COPYA;
                            bus.alu_a_sel = A_UIMM;
                            bus.rf_we     = 1'b1;
                            bus.pc_we     = 1'b1;
                            bus.retire    = 1'b1;
                        end
                        OPC_AUIPC: begin
                            bus.alu_a_sel = A_PC;
                            bus.alu_b_sel = B_IMM;
                            bus.rf_we     = 1'b1;
                            bus.pc_we     = 1'b1;
                            bus.retire    = 1'b1;
                        end
                        OPC_BRANCH: begin
                            bus.alu_a_sel = A_PC;
                            bus.alu_b_sel = B_IMM;
                            bus.pc_we     = 1'b1;
                            bus.pc_sel    = bus.br_taken ? PC_ALU : PC_PLUS4;
                            bus.retire    = 1'b1;
                        end
                        OPC_JAL: begin
                            bus.alu_a_sel = A_PC;
                            bus.alu_b_sel = B_IMM;
                            bus.rf_we     = 1'b1;
                            bus.wb_sel    = WB_PC4;
                            bus.pc_we     = 1'b1;
                            bus.pc_sel    = PC_ALU;
                            bus.retire    = 1'b1;
                        end
                        OPC_JALR: begin
                            bus.alu_b_sel = B_IMM;
                            bus.rf_we     = 1'b1;
                            bus.wb_sel    = WB_PC4;
                            bus.pc_we     = 1'b1;
                            bus.pc_sel    = PC_ALU_AL;
                            bus.retire    = 1'b1;
                        end
                        OPC_LOAD, OPC_STORE: begin
                            bus.alu_b_sel = B_IMM;
                        end
                        default: ;
                    endcase
                end
                MEM: begin
                    // Address path held at rs1+imm so the registered result stays valid.
                    bus.alu_b_sel    = B_IMM;
                    bus.mem_req      = 1'b1;
                    bus.mem_addr_sel = 1'b1;
                    bus.mem_we       = (opcode == OPC_STORE);
                    if (bus.mem_ready) begin
                        bus.pc_we  = 1'b1;
                        bus.retire = 1'b1;
                        if (opcode == OPC_LOAD) begin
                            bus.rf_we  = 1'b1;
                            bus.wb_sel = WB_MEM;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ctrl_fsm.sv
// Self-checking bench for ctrl_fsm: directed test-plan steps then random
// instruction streams compared cycle-by-cycle against a per-instruction model.
module tb_ctrl_fsm;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ctrl_fsm_if bus ();
    ctrl_fsm dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_chk = 0;
    int n_pass = 0;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       mem_addr_sel;
        logic       ir_we;
        logic       pc_we;
        logic [1:0] pc_sel;
        logic       rf_we;
        logic [1:0] wb_sel;
        logic [3:0] alu_op;
        logic [1:0] a_sel;
        logic       b_sel;
        logic       retire;
        logic       illegal;
        logic [2:0] state;
    } obs_t;

    localparam logic [6:0] OP = 7'h33, OPI = 7'h13, LD = 7'h03, ST = 7'h23, BR = 7'h63,
                           JAL = 7'h6F, JALR = 7'h67, LUI = 7'h37, AUIPC = 7'h17;

    function automatic obs_t observe();
        obs_t o;
        o = '{bus.mem_req, bus.mem_we, bus.mem_addr_sel, bus.ir_we, bus.pc_we, bus.pc_sel,
              bus.rf_we, bus.wb_sel, bus.alu_op, bus.alu_a_sel, bus.alu_b_sel,
              bus.retire, bus.illegal, bus.state};
        return o;
    endfunction

    task automatic chk(input string tag, input obs_t exp);
        obs_t o;
        o = observe();
        n_chk++;
        assert (o === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, o, exp);
    endtask

    // Reference legality: the RV32I subset accepted by this core.
    function automatic logic legal_m(input logic [31:0] ins);
        logic [2:0] f3;
        logic [6:0] f7;
        f3 = ins[14:12];
        f7 = ins[31:25];
        case (ins[6:0])
            OP:   return f7 == 7'h00 || (f7 == 7'h20 && f3 inside {3'd0, 3'd5});
            OPI:  return (f3 == 3'd1) ? (f7 == 7'h00) :
                         (f3 == 3'd5) ? (f7 inside {7'h00, 7'h20}) : 1'b1;
            LD:   return f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
            ST:   return f3 inside {3'd0, 3'd1, 3'd2};
            BR:   return !(f3 inside {3'd2, 3'd3});
            JALR: return f3 == 3'd0;
            JAL, LUI, AUIPC: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic obs_t exec_m(input logic [31:0] ins, input logic br);
        obs_t e;
        logic [2:0] f3;
        f3 = ins[14:12];
        e = '0;
        e.state = 3'd2;
        case (ins[6:0])
            OP:    begin e.alu_op = 4'(f3) + (ins[30] ? 4'd8 : 4'd0);
                         e.rf_we = 1; e.pc_we = 1; e.retire = 1; end
            OPI:   begin e.alu_op = (f3 == 3'd5 && ins[30]) ? 4'd13 : 4'(f3); e.b_sel = 1;
                         e.rf_we = 1; e.pc_we = 1; e.retire = 1; end
            LUI:   begin e.alu_op = 4'd9; e.a_sel = 2; e.rf_we = 1; e.pc_we = 1; e.retire = 1; end
            AUIPC: begin e.a_sel = 1; e.b_sel = 1; e.rf_we = 1; e.pc_we = 1; e.retire = 1; end
            BR:    begin e.a_sel = 1; e.b_sel = 1; e.pc_we = 1; e.pc_sel = br ? 2'd1 : 2'd0;
                         e.retire = 1; end
            JAL:   begin e.a_sel = 1; e.b_sel = 1; e.rf_we = 1; e.wb_sel = 2; e.pc_we = 1;
                         e.pc_sel = 1; e.retire = 1; end
            JALR:  begin e.b_sel = 1; e.rf_we = 1; e.wb_sel = 2; e.pc_we = 1;
                         e.pc_sel = 2; e.retire = 1; end
            default: e.b_sel = 1;
        endcase
        return e;
    endfunction

    function automatic obs_t mem_m(input logic [31:0] ins, input logic rdy);
        obs_t e;
        e = '0;
        e.state = 3'd3;
        e.b_sel = 1;
        e.mem_req = 1;
        e.mem_addr_sel = 1;
        e.mem_we = (ins[6:0] == ST);
        if (rdy) begin
            e.pc_we = 1;
            e.retire = 1;
            if (ins[6:0] == LD) begin e.rf_we = 1; e.wb_sel = 1; end
        end
        return e;
    endfunction

    function automatic obs_t fetch_m(input logic rdy);
        obs_t e;
        e = '0;
        e.mem_req = 1;
        e.ir_we = rdy;
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entered just after a rising edge with the DUT in FETCH.
    task automatic run_instr(input logic [31:0] ins, input logic br, input int fw,
                             input int mw, input string tag);
        obs_t e;
        bus.instr = ins;
        for (int i = 0; i <= fw; i++) begin
            bus.mem_ready = (i == fw);
            bus.br_taken = 1'($urandom);
            @(negedge clk); chk({tag, " fetch"}, fetch_m(i == fw)); step();
        end
        bus.mem_ready = 1'($urandom);
        e = '0; e.state = 3'd1;
        @(negedge clk); chk({tag, " decode"}, e); step();
        if (!legal_m(ins)) return;
        bus.br_taken = br;
        bus.mem_ready = 1'($urandom);
        @(negedge clk); chk({tag, " exec"}, exec_m(ins, br)); step();
        if (ins[6:0] inside {LD, ST}) begin
            for (int i = 0; i <= mw; i++) begin
                bus.mem_ready = (i == mw);
                @(negedge clk); chk({tag, " mem"}, mem_m(ins, i == mw)); step();
            end
        end
    endtask

    task automatic halt_cycles(input int n, input string tag);
        obs_t e;
        e = '0; e.illegal = 1; e.state = 3'd4;
        for (int i = 0; i < n; i++) begin
            bus.mem_ready = 1'($urandom);
            @(negedge clk); chk({tag, " halt"}, e); step();
        end
    endtask

    task automatic do_reset(input logic rdy, input string tag);
        rst_n = 1'b0;
        bus.mem_ready = rdy;
        #2 chk({tag, " in reset"}, '0);
        step();
        rst_n = 1'b1;
        bus.mem_ready = 1'b0;
        @(negedge clk); chk({tag, " after reset"}, fetch_m(1'b0)); step();
    endtask

    function automatic logic [31:0] rand_legal();
        logic [6:0] ops [9];
        logic [31:0] ins;
        ops = '{OP, OPI, LD, ST, BR, JAL, JALR, LUI, AUIPC};
        do begin
            ins = $urandom;
            ins[6:0] = ops[$urandom_range(0, 8)];
            if (ins[6:0] inside {OP, OPI})
                ins[31:25] = ($urandom_range(0, 1) != 0) ? 7'h00 : 7'h20;
        end while (!legal_m(ins));
        return ins;
    endfunction

    initial begin
        obs_t e;
        logic [31:0] ins;
        bus.instr = '0;
        bus.mem_ready = 1'b0;
        bus.br_taken = 1'b0;
        step();
        do_reset(1'b1, "por");

        run_instr(32'h002081B3, 1'b0, 0, 0, "add");
        run_instr(32'h402081B3, 1'b0, 0, 0, "sub");
        run_instr(32'h40335293, 1'b0, 0, 0, "srai");
        run_instr(32'h00032283, 1'b0, 0, 2, "lw_wait");
        run_instr(32'h00000463, 1'b1, 0, 0, "beq_taken");
        run_instr(32'h00000463, 1'b0, 1, 0, "beq_not");

        run_instr(32'hFFFFFFFF, 1'b0, 0, 0, "illegal");
        halt_cycles(10, "illegal");
        do_reset(1'b1, "illegal");

        // Reset landing in a LOAD's MEM cycle with ready up must not write back.
        bus.instr = 32'h00032283;
        bus.mem_ready = 1'b1;
        step(); step(); step();
        bus.mem_ready = 1'b0;
        @(negedge clk); chk("midmem wait", mem_m(32'h00032283, 1'b0)); step();
        do_reset(1'b1, "midmem");

        for (int n = 0; n < 150; n++) begin
            ins = ($urandom_range(0, 9) == 0) ? 32'($urandom) : rand_legal();
            run_instr(ins, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 3), "rand");
            if (!legal_m(ins)) begin
                halt_cycles(3, "rand");
                do_reset(1'($urandom), "rand");
            end
        end

        e = fetch_m(1'b0);
        bus.mem_ready = 1'b0;
        @(negedge clk); chk("final fetch", e);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
